// File: rtl/network_pkg.sv
// Shared network types and constants for the classifier front end.
package network_pkg;

  // Classifier 5-tuple, network byte order within each field.
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  protocol;
  } packet_s;

  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHTYPE_VLAN = 16'h8100;
  localparam logic [7:0]  PROTO_TCP    = 8'd6;
  localparam logic [7:0]  PROTO_UDP    = 8'd17;

  // Offset of the IPv4 header from frame start, untagged and single-tagged.
  localparam logic [10:0] L3_OFF      = 11'd14;
  localparam logic [10:0] L3_OFF_VLAN = 11'd18;

  typedef enum logic [1:0] {StEth, StIp, StL4, StDrain} parse_state_e;

endpackage

// File: rtl/tuple_fifo.sv
// Synchronous tuple FIFO. A push into a full FIFO is accepted when a pop happens in the
// same cycle; otherwise it is ignored and the caller accounts for the loss.
module tuple_fifo
  import network_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  packet_s                wdata_i,
  output packet_s                rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AW = $clog2(Depth);

  packet_s       mem_q [Depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(Depth));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/tuple_extractor.sv
// Parses an Ethernet II / IPv4 / TCP-UDP byte stream into 5-tuples, buffers them and
// dispatches them to the classifier one pulse at a time. Define TUPLE_VLAN_EN to accept
// a single 802.1Q tag in front of the IPv4 ethertype.
module tuple_extractor
  import network_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  input  logic                        cls_ready,
  output logic                        cls_valid,
  output logic [31:0]                 cls_src_ip,
  output logic [31:0]                 cls_dst_ip,
  output logic [15:0]                 cls_src_port,
  output logic [15:0]                 cls_dst_port,
  output logic [7:0]                  cls_protocol,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]            frames_ok,
  output logic [CNT_W-1:0]            frames_drop,
  output logic [CNT_W-1:0]            fifo_ovf
);

  parse_state_e state_q;
  logic [10:0]  cnt_q, cnt_inc, l3_off, ip_off, l4_off, tag_pos;
  logic         vlan_q, s_ready_q, push_q, cls_valid_q;
  logic [7:0]   type_hi_q, proto_q;
  logic [3:0]   ihl_q;
  logic [12:0]  frag_q;
  logic [31:0]  src_ip_q, dst_ip_q;
  logic [15:0]  src_port_q, dst_port_q, etype;
  packet_s      push_tuple_q, tuple_now, fifo_rdata, cls_tuple_q;
  logic         beat, l4_go, set_vlan, to_ip, to_l4, bad, done, drop_evt;
  logic         fifo_full, fifo_empty, pop;
  logic [CNT_W-1:0] ok_q, drop_q, ovf_q;

  assign beat    = s_valid && s_ready_q;
  assign cnt_inc = (cnt_q == 11'h7ff) ? cnt_q : cnt_q + 11'd1;
  assign l3_off  = vlan_q ? L3_OFF_VLAN : L3_OFF;
  assign tag_pos = vlan_q ? 11'd17 : 11'd13;
  assign ip_off  = cnt_q - l3_off;
  assign l4_off  = ip_off - {5'd0, ihl_q, 2'b00};
  assign etype   = {type_hi_q, s_data};
  assign l4_go   = ((proto_q == PROTO_TCP) || (proto_q == PROTO_UDP)) && (frag_q == '0);

`ifdef TUPLE_VLAN_EN
  // Only one tag is allowed; a second 0x8100 falls through to the drop path.
  assign set_vlan = (state_q == StEth) && (cnt_q == 11'd13) && !vlan_q && (etype == ETHTYPE_VLAN);
`else
  assign set_vlan = 1'b0;
`endif

  assign to_ip = (state_q == StEth) && (cnt_q == tag_pos) && (etype == ETHTYPE_IPV4);
  assign to_l4 = (state_q == StIp) && (ip_off == 11'd19) && l4_go;
  assign bad   = ((state_q == StEth) && (cnt_q == tag_pos) && !to_ip && !set_vlan) ||
                 ((state_q == StIp) && (ip_off == 11'd0) &&
                  ((s_data[7:4] != 4'd4) || (s_data[3:0] < 4'd5)));
  assign done  = ((state_q == StIp) && (ip_off == 11'd19) && !l4_go) ||
                 ((state_q == StL4) && (l4_off == 11'd3));
  assign drop_evt = beat && (bad || (s_last && !done && (state_q != StDrain)));

  // Tuple as it stands once the completing byte is folded in.
  always_comb begin
    tuple_now.src_ip   = src_ip_q;
    tuple_now.dst_ip   = dst_ip_q;
    tuple_now.src_port = src_port_q;
    tuple_now.dst_port = {dst_port_q[7:0], s_data};
    tuple_now.protocol = proto_q;
    if (state_q == StIp) begin
      tuple_now.dst_ip   = {dst_ip_q[23:0], s_data};
      tuple_now.src_port = '0;
      tuple_now.dst_port = '0;
    end
  end

  // Per-byte parser: frame offset, header field capture, state and hand-off to the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StEth;
      cnt_q        <= '0;
      vlan_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      type_hi_q    <= '0;
      ihl_q        <= '0;
      proto_q      <= '0;
      frag_q       <= '0;
      src_ip_q     <= '0;
      dst_ip_q     <= '0;
      src_port_q   <= '0;
      dst_port_q   <= '0;
      push_q       <= 1'b0;
      push_tuple_q <= '0;
    end else begin
      s_ready_q <= 1'b1;
      push_q    <= 1'b0;
      if (beat) begin
        cnt_q <= s_last ? '0 : cnt_inc;
        if ((state_q == StEth) && ((cnt_q == 11'd12) || (cnt_q == 11'd16))) type_hi_q <= s_data;
        if (state_q == StIp) begin
          if (ip_off == 11'd0) ihl_q <= s_data[3:0];
          if (ip_off == 11'd6) frag_q[12:8] <= s_data[4:0];
          if (ip_off == 11'd7) frag_q[7:0] <= s_data;
          if (ip_off == 11'd9) proto_q <= s_data;
          if ((ip_off >= 11'd12) && (ip_off <= 11'd15)) src_ip_q <= {src_ip_q[23:0], s_data};
          if ((ip_off >= 11'd16) && (ip_off <= 11'd19)) dst_ip_q <= {dst_ip_q[23:0], s_data};
        end
        if (state_q == StL4) begin
          if (l4_off <= 11'd1)      src_port_q <= {src_port_q[7:0], s_data};
          else if (l4_off <= 11'd3) dst_port_q <= {dst_port_q[7:0], s_data};
        end
        if (bad) begin
          state_q <= s_last ? StEth : StDrain;
        end else if (done) begin
          push_q       <= 1'b1;
          push_tuple_q <= tuple_now;
          state_q      <= s_last ? StEth : StDrain;
        end else if (s_last) begin
          state_q <= StEth;
        end else if (set_vlan) begin
          vlan_q <= 1'b1;
        end else if (to_ip) begin
          state_q <= StIp;
        end else if (to_l4) begin
          state_q <= StL4;
        end
        if (s_last) vlan_q <= 1'b0;
      end
    end
  end

  tuple_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_q),
    .pop_i   (pop),
    .wdata_i (push_tuple_q),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Idle cycle after each pulse lets the classifier's registered ready fall first.
  assign pop = !fifo_empty && cls_ready && !cls_valid_q;

  // Dispatch: single-cycle valid with fields held until the next pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cls_valid_q <= 1'b0;
      cls_tuple_q <= '0;
    end else begin
      cls_valid_q <= pop;
      if (pop) cls_tuple_q <= fifo_rdata;
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      ok_q   <= '0;
      drop_q <= '0;
      ovf_q  <= '0;
    end else begin
      if (push_q && (!fifo_full || pop) && !(&ok_q)) ok_q <= ok_q + CNT_W'(1);
      if (push_q && fifo_full && !pop && !(&ovf_q))  ovf_q <= ovf_q + CNT_W'(1);
      if (drop_evt && !(&drop_q))                    drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign s_ready      = s_ready_q;
  assign cls_valid    = cls_valid_q;
  assign cls_src_ip   = cls_tuple_q.src_ip;
  assign cls_dst_ip   = cls_tuple_q.dst_ip;
  assign cls_src_port = cls_tuple_q.src_port;
  assign cls_dst_port = cls_tuple_q.dst_port;
  assign cls_protocol = cls_tuple_q.protocol;
  assign frames_ok    = ok_q;
  assign frames_drop  = drop_q;
  assign fifo_ovf     = ovf_q;

endmodule

// File: tb/tb_tuple_extractor.sv
// Directed bench for tuple_extractor; the VLAN step follows TUPLE_VLAN_EN.
module tb_tuple_extractor;
  import network_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_ready;
  logic        cls_ready, cls_valid;
  logic [31:0] cls_src_ip, cls_dst_ip;
  logic [15:0] cls_src_port, cls_dst_port;
  logic [7:0]  cls_protocol;
  logic [3:0]  fifo_count;
  logic [15:0] frames_ok, frames_drop, fifo_ovf;

  always #5 clk = ~clk;

  tuple_extractor #(
    .FIFO_DEPTH(8),
    .CNT_W     (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .cls_ready   (cls_ready),
    .cls_valid   (cls_valid),
    .cls_src_ip  (cls_src_ip),
    .cls_dst_ip  (cls_dst_ip),
    .cls_src_port(cls_src_port),
    .cls_dst_port(cls_dst_port),
    .cls_protocol(cls_protocol),
    .fifo_count  (fifo_count),
    .frames_ok   (frames_ok),
    .frames_drop (frames_drop),
    .fifo_ovf    (fifo_ovf)
  );

  int         tests = 0;
  int         fails = 0;
  int         adj = 0;
  logic       prev_v = 1'b0;
  logic [7:0] frm[$];
  packet_s    obs[$];
  packet_s    mon_t;

  assign mon_t = '{src_ip: cls_src_ip, dst_ip: cls_dst_ip, src_port: cls_src_port,
                   dst_port: cls_dst_port, protocol: cls_protocol};

  // Record every dispatched tuple and flag back-to-back pulses.
  always @(negedge clk) begin
    if (cls_valid) begin
      obs.push_back(mon_t);
      if (prev_v) adj <= adj + 1;
    end
    prev_v <= cls_valid;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pk(input packet_s t);
    return {24'd0, t};
  endfunction

  function automatic packet_s obs_at(input int k);
    if (k < obs.size()) return obs[k];
    return '0;
  endfunction

  function automatic packet_s tup(input logic [31:0] s, input logic [31:0] d,
                                  input logic [15:0] sp, input logic [15:0] dp,
                                  input logic [7:0] pr);
    packet_s t;
    t.src_ip = s; t.dst_ip = d; t.src_port = sp; t.dst_port = dp; t.protocol = pr;
    return t;
  endfunction

  task automatic build(input bit vlan, input logic [15:0] et, input logic [7:0] vihl,
                       input logic [7:0] proto, input logic [15:0] frag,
                       input logic [31:0] sip, input logic [31:0] dip,
                       input logic [15:0] sp, input logic [15:0] dp);
    int nopt;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(8'hFF);
    for (int i = 0; i < 6; i++) frm.push_back(8'h02);
    if (vlan) begin
      frm.push_back(8'h81); frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h07);
    end
    frm.push_back(et[15:8]); frm.push_back(et[7:0]);
    frm.push_back(vihl); frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h3C);
    frm.push_back(8'h12); frm.push_back(8'h34); frm.push_back(frag[15:8]); frm.push_back(frag[7:0]);
    frm.push_back(8'h40); frm.push_back(proto); frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 3; i >= 0; i--) frm.push_back(sip[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) frm.push_back(dip[i*8 +: 8]);
    nopt = (int'(vihl[3:0]) > 5) ? (int'(vihl[3:0]) - 5) * 4 : 0;
    for (int i = 0; i < nopt; i++) frm.push_back(8'hEE);
    frm.push_back(sp[15:8]); frm.push_back(sp[7:0]);
    frm.push_back(dp[15:8]); frm.push_back(dp[7:0]);
    for (int i = 0; i < 4; i++) frm.push_back(8'hA5);
  endtask

  task automatic send(input int gap);
    for (int i = 0; i < frm.size(); i++) begin
      s_valid = 1'b1;
      s_data  = frm[i];
      s_last  = (i == frm.size() - 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; cls_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", 128'(s_ready), 128'(0));
    check("rst_cls_valid", 128'(cls_valid), 128'(0));
    check("rst_fifo_count", 128'(fifo_count), 128'(0));
    check("rst_frames_ok", 128'(frames_ok), 128'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    check("s_ready_after_rst", 128'(s_ready), 128'(1));
    cls_ready = 1'b1;

    // UDP, IHL=5.
    build(0, 16'h0800, 8'h45, 8'd17, 16'h0, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd53);
    send(10);
    check("udp_pulses", 128'(obs.size()), 128'(1));
    check("udp_tuple", pk(obs_at(0)), pk(tup(32'h0A000001, 32'h0A000002, 16'd1234, 16'd53, 8'd17)));
    check("udp_frames_ok", 128'(frames_ok), 128'(1));

    // TCP with 8 option bytes: ports start at byte 42.
    build(0, 16'h0800, 8'h47, 8'd6, 16'h0, 32'hC0A80001, 32'hC0A80002, 16'h1F90, 16'h0050);
    send(10);
    check("tcp_ihl7_tuple", pk(obs_at(1)), pk(tup(32'hC0A80001, 32'hC0A80002, 16'h1F90, 16'h0050, 8'd6)));

    // ICMP and fragmented UDP: ports forced to zero.
    build(0, 16'h0800, 8'h45, 8'd1, 16'h0, 32'h01020304, 32'h05060708, 16'hBEEF, 16'hCAFE);
    send(10);
    check("icmp_tuple", pk(obs_at(2)), pk(tup(32'h01020304, 32'h05060708, 16'h0, 16'h0, 8'd1)));
    build(0, 16'h0800, 8'h45, 8'd17, 16'h0010, 32'h0A0A0A0A, 32'h0B0B0B0B, 16'h1111, 16'h2222);
    send(10);
    check("frag_tuple", pk(obs_at(3)), pk(tup(32'h0A0A0A0A, 32'h0B0B0B0B, 16'h0, 16'h0, 8'd17)));
    check("frames_ok_4", 128'(frames_ok), 128'(4));

    // Drops: IPv6 ethertype, truncated after byte 25, bad version, IHL below 5.
    build(0, 16'h86DD, 8'h45, 8'd17, 16'h0, 32'h1, 32'h2, 16'h3, 16'h4);
    send(4);
    build(0, 16'h0800, 8'h45, 8'd17, 16'h0, 32'h1, 32'h2, 16'h3, 16'h4);
    while (frm.size() > 26) void'(frm.pop_back());
    send(4);
    build(0, 16'h0800, 8'h55, 8'd17, 16'h0, 32'h1, 32'h2, 16'h3, 16'h4);
    send(4);
    build(0, 16'h0800, 8'h44, 8'd17, 16'h0, 32'h1, 32'h2, 16'h3, 16'h4);
    send(10);
    check("drop_no_pulse", 128'(obs.size()), 128'(4));
    check("frames_drop_4", 128'(frames_drop), 128'(4));

    // Ten frames with the classifier stalled: eight buffered, two lost.
    cls_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      build(0, 16'h0800, 8'h45, 8'd17, 16'h0, 32'h0A000001, 32'h0A000002,
            16'h0100 + 16'(i), 16'd53);
      send(2);
    end
    repeat (5) @(posedge clk);
    #1;
    check("ovf_fifo_count", 128'(fifo_count), 128'(8));
    check("ovf_count", 128'(fifo_ovf), 128'(2));
    check("ovf_frames_ok", 128'(frames_ok), 128'(12));
    check("ovf_no_pulse", 128'(obs.size()), 128'(4));

    // Classifier model: ready drops the cycle after each pulse.
    cls_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      cls_ready = !cls_valid;
    end
    cls_ready = 1'b1;
    check("drain_pulses", 128'(obs.size()), 128'(12));
    for (int k = 0; k < 8; k++)
      check("drain_order", 128'(obs_at(4 + k).src_port), 128'(16'h0100 + 16'(k)));
    check("drain_no_adjacent", 128'(adj), 128'(0));
    check("drain_fifo_empty", 128'(fifo_count), 128'(0));

    // Single 802.1Q tag.
    build(1, 16'h0800, 8'h45, 8'd17, 16'h0, 32'hAC100001, 32'hAC100002, 16'h1111, 16'h2222);
    send(10);
`ifdef TUPLE_VLAN_EN
    check("vlan_pulses", 128'(obs.size()), 128'(13));
    check("vlan_tuple", pk(obs_at(12)), pk(tup(32'hAC100001, 32'hAC100002, 16'h1111, 16'h2222, 8'd17)));
    check("vlan_frames_ok", 128'(frames_ok), 128'(13));
`else
    check("vlan_no_pulse", 128'(obs.size()), 128'(12));
    check("vlan_dropped", 128'(frames_drop), 128'(5));
`endif

    // Reset empties a non-empty FIFO and clears statistics.
    cls_ready = 1'b0;
    build(0, 16'h0800, 8'h45, 8'd17, 16'h0, 32'h1, 32'h2, 16'h3, 16'h4);
    send(5);
    check("pre_reset_count", 128'(fifo_count), 128'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_fifo_count", 128'(fifo_count), 128'(0));
    check("reset_frames_ok", 128'(frames_ok), 128'(0));
    check("reset_frames_drop", 128'(frames_drop), 128'(0));
    check("reset_fifo_ovf", 128'(fifo_ovf), 128'(0));
    check("reset_s_ready", 128'(s_ready), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
